// File: rtl/taxi_apb_pkg.sv
// taxi_apb_pkg: shared types and constants for the APB register bridge.
// Contents:
//   apb_reg_state_t - bridge state machine encoding (IDLE, REQ, RESP)
//   PRIV/NONSEC/INSTR - bit positions within pprot
package taxi_apb_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP} apb_reg_state_t;

    localparam int PRIV   = 0;
    localparam int NONSEC = 1;
    localparam int INSTR  = 2;

endpackage

// File: rtl/taxi_apb_if.sv
// taxi_apb_if: APB bus bundle.
// Parameters: DATA_W, ADDR_W, STRB_W = DATA_W/8.
// Modports: mst (requester side), slv (completer side).
interface taxi_apb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int STRB_W = DATA_W / 8
) ();

    logic [ADDR_W-1:0] paddr;
    logic [2:0]        pprot;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport mst (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slv (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/taxi_apb_reg_bridge.sv
// taxi_apb_reg_bridge: APB completer to single-outstanding register req/ack bridge.
// Ports:
//   clk, rst            - clock, async active-high reset
//   s_apb               - APB completer port (taxi_apb_if.slv)
//   reg_req             - request valid, held until ack or timeout
//   reg_we              - 1 = write, 0 = read
//   reg_addr/wdata/wstrb/prot - latched APB setup-phase fields (wstrb 0 on reads)
//   reg_ack             - completion, sampled only while reg_req is high
//   reg_rdata, reg_err  - read data and error flag, valid with reg_ack
// Optional feature: define TAXI_APB_REG_BRIDGE_TIMEOUT_EN to force an error
// response after TIMEOUT request cycles without an ack.
module taxi_apb_reg_bridge
    import taxi_apb_pkg::*;
#(
    parameter int TIMEOUT   = 256,
    parameter int TIMEOUT_W = $clog2(TIMEOUT + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    taxi_apb_if.slv                       s_apb,
    output logic                          reg_req,
    output logic                          reg_we,
    output logic [s_apb.ADDR_W-1:0]       reg_addr,
    output logic [s_apb.DATA_W-1:0]       reg_wdata,
    output logic [s_apb.STRB_W-1:0]       reg_wstrb,
    output logic [2:0]                    reg_prot,
    input  logic                          reg_ack,
    input  logic [s_apb.DATA_W-1:0]       reg_rdata,
    input  logic                          reg_err
);

    apb_reg_state_t state;
    logic           tmo;

`ifdef TAXI_APB_REG_BRIDGE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt;

    // Fires during the TIMEOUT-th request cycle; the counter idles at zero
    // so it is already cleared when the next request starts.
    assign tmo = state == REQ && cnt == TIMEOUT_W'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= (state == REQ && !reg_ack && !tmo) ? cnt + 1'b1 : '0;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            reg_req       <= 1'b0;
            reg_we        <= 1'b0;
            reg_addr      <= '0;
            reg_wdata     <= '0;
            reg_wstrb     <= '0;
            reg_prot      <= '0;
            s_apb.pready  <= 1'b0;
            s_apb.pslverr <= 1'b0;
            s_apb.prdata  <= '0;
        end else begin
            case (state)
                IDLE: if (s_apb.psel && !s_apb.penable) begin
                    reg_req   <= 1'b1;
                    reg_we    <= s_apb.pwrite;
                    reg_addr  <= s_apb.paddr;
                    reg_wdata <= s_apb.pwdata;
                    reg_wstrb <= s_apb.pwrite ? s_apb.pstrb : '0;
                    reg_prot  <= s_apb.pprot;
                    state     <= REQ;
                end
                // An ack in the timeout cycle still wins and supplies the response.
                REQ: if (reg_ack || tmo) begin
                    s_apb.prdata  <= (reg_ack && !reg_we) ? reg_rdata : '0;
                    s_apb.pslverr <= reg_ack ? reg_err : 1'b1;
                    s_apb.pready  <= 1'b1;
                    reg_req       <= 1'b0;
                    state         <= RESP;
                end
                RESP: begin
                    s_apb.pready  <= 1'b0;
                    s_apb.pslverr <= 1'b0;
                    s_apb.prdata  <= '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_taxi_apb_reg_bridge.sv
// tb_taxi_apb_reg_bridge: self-checking bench for the APB register bridge.
module tb_taxi_apb_reg_bridge;

    localparam int TMO = 8;
`ifdef TAXI_APB_REG_BRIDGE_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    taxi_apb_if #(.DATA_W(32), .ADDR_W(16)) apb ();

    logic        reg_req, reg_we;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic [2:0]  reg_prot;
    logic        reg_ack, reg_err;
    logic [31:0] reg_rdata;

    int checks = 0;
    int passes = 0;

    taxi_apb_reg_bridge #(.TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .s_apb(apb),
        .reg_req(reg_req),
        .reg_we(reg_we),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_wstrb(reg_wstrb),
        .reg_prot(reg_prot),
        .reg_ack(reg_ack),
        .reg_rdata(reg_rdata),
        .reg_err(reg_err)
    );

    // Reference: an ack in request cycle k (k <= TIMEOUT when enabled) ends
    // the request after k cycles; otherwise the timeout ends it after TIMEOUT.
    function automatic bit model_acked(int ack_at);
        return ack_at != 0 && (!TEN || ack_at <= TMO);
    endfunction

    function automatic int model_req_cycles(int ack_at);
        return model_acked(ack_at) ? ack_at : TMO;
    endfunction

    task automatic xfer(input bit we, input logic [15:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr, input int ack_at,
                        input logic [31:0] rd, input bit er, input bit early, input string nm);
        int n = 0;
        int reqc = 0;
        bit done = 1'b0;
        bit fok = 1'b1;
        logic [31:0] got_rd = '0;
        logic got_err = 1'b0;
        logic [31:0] exp_rd;
        bit exp_err;
        int exp_req;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = we; apb.paddr = a;
        apb.pwdata = wd; apb.pstrb = st; apb.pprot = pr;
        @(posedge clk);
        #1 apb.penable = 1'b1;
        while (!done && n < 600) begin
            @(negedge clk);
            n++;
            if (early && n == 1) begin apb.psel = 1'b0; apb.penable = 1'b0; end
            if (early && n == 2) begin apb.psel = 1'b1; apb.paddr = ~a; apb.pwrite = !we; end
            if (early && n == 3) apb.psel = 1'b0;
            reg_ack = 1'b0;
            if (apb.pready) begin
                done = 1'b1;
                got_rd = apb.prdata;
                got_err = apb.pslverr;
            end else if (reg_req) begin
                reqc++;
                if (reg_we !== we || reg_addr !== a || reg_wdata !== wd ||
                    reg_wstrb !== (we ? st : 4'h0) || reg_prot !== pr) fok = 1'b0;
                if (reqc == ack_at) begin
                    reg_ack = 1'b1; reg_rdata = rd; reg_err = er;
                end else begin
                    reg_rdata = $urandom; reg_err = 1'($urandom);
                end
            end
        end
        reg_ack = 1'b0;
        @(posedge clk);
        #1 apb.psel = 1'b0; apb.penable = 1'b0;
        exp_req = model_req_cycles(ack_at);
        exp_rd = (we || !model_acked(ack_at)) ? 32'h0 : rd;
        exp_err = model_acked(ack_at) ? er : 1'b1;
        checks++;
        if (!done || n !== exp_req + 1) $display("FAIL %s pready_cycle: got %0d want %0d (done=%0d)", nm, n, exp_req + 1, done);
        else passes++;
        checks++;
        if (reqc !== exp_req) $display("FAIL %s req_cycles: got %0d want %0d", nm, reqc, exp_req);
        else passes++;
        checks++;
        if (fok !== 1'b1) $display("FAIL %s req_fields: got bad want latched a=%h wd=%h st=%h pr=%h we=%0d", nm, a, wd, st, pr, we);
        else passes++;
        checks++;
        if (got_rd !== exp_rd) $display("FAIL %s prdata: got %h want %h", nm, got_rd, exp_rd);
        else passes++;
        checks++;
        if (got_err !== exp_err) $display("FAIL %s pslverr: got %0d want %0d", nm, got_err, exp_err);
        else passes++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb, reg_prot} !== '0)
            $display("FAIL reset_reg: got %h want 0", {reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb, reg_prot});
        else passes++;
        checks++;
        if ({apb.pready, apb.pslverr, apb.prdata} !== '0)
            $display("FAIL reset_apb: got %h want 0", {apb.pready, apb.pslverr, apb.prdata});
        else passes++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_imm();
        xfer(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b000, 1, 32'h0, 1'b0, 1'b0, "write_imm");
    endtask

    task automatic test_read_delay();
        xfer(1'b0, 16'h0024, 32'h0, 4'h0, 3'b011, 5, 32'h12345678, 1'b0, 1'b0, "read_5");
    endtask

    task automatic test_reg_err();
        xfer(1'b0, 16'h0030, 32'h0, 4'hA, 3'b101, 2, 32'hCAFEF00D, 1'b1, 1'b0, "reg_err_rd");
        xfer(1'b1, 16'h0034, 32'h55AA55AA, 4'h3, 3'b010, 3, 32'hFFFFFFFF, 1'b1, 1'b0, "reg_err_wr");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            xfer(1'($urandom), 16'($urandom), $urandom, 4'($urandom), 3'($urandom),
                 int'($urandom_range(1, TEN ? 11 : 6)), $urandom, 1'($urandom), 1'b0, "random");
    endtask

    task automatic test_back_to_back();
        xfer(1'b1, 16'h0100, 32'h01020304, 4'h5, 3'b001, 1, 32'h0, 1'b0, 1'b0, "b2b_0");
        xfer(1'b0, 16'h0104, 32'h0, 4'h0, 3'b001, 1, 32'hA5A5A5A5, 1'b0, 1'b0, "b2b_1");
        xfer(1'b0, 16'h0108, 32'h0, 4'h0, 3'b100, 1, 32'h5A5A5A5A, 1'b1, 1'b0, "b2b_2");
    endtask

    task automatic test_early_psel();
        xfer(1'b0, 16'h0200, 32'h0, 4'h0, 3'b110, 4, 32'h0BADC0DE, 1'b0, 1'b1, "early_psel");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (reg_req !== 1'b0) $display("FAIL early_ghost_req: got %0d want 0", reg_req);
            else passes++;
        end
        @(posedge clk);
        #1;
    endtask

`ifdef TAXI_APB_REG_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        xfer(1'b0, 16'h0300, 32'h0, 4'h0, 3'b000, 0, 32'h0, 1'b0, 1'b0, "timeout");
        reg_ack = 1'b1; reg_rdata = 32'h77777777; reg_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({reg_req, apb.pready} !== 2'b00) $display("FAIL late_ack: got %b want 00", {reg_req, apb.pready});
            else passes++;
        end
        reg_ack = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ack_at_timeout();
        xfer(1'b0, 16'h0304, 32'h0, 4'h0, 3'b000, TMO, 32'h13572468, 1'b0, 1'b0, "ack_at_tmo");
    endtask
`endif

    task automatic test_async_reset();
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 16'h0400;
        apb.pwdata = 32'h11112222; apb.pstrb = 4'hF; apb.pprot = 3'b000;
        @(posedge clk);
        #1 apb.penable = 1'b1;
        @(negedge clk);
        checks++;
        if (reg_req !== 1'b1) $display("FAIL arst_pre_req: got %0d want 1", reg_req);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({reg_req, apb.pready, reg_addr} !== '0) $display("FAIL arst_clear: got %h want 0", {reg_req, apb.pready, reg_addr});
        else passes++;
        apb.psel = 1'b0; apb.penable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        xfer(1'b0, 16'h0408, 32'h0, 4'h0, 3'b010, 2, 32'h89ABCDEF, 1'b0, 1'b0, "arst_read");
    endtask

    initial begin
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0;
        apb.pwdata = '0; apb.pstrb = '0; apb.pprot = '0;
        reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;
        test_reset();
        test_write_imm();
        test_read_delay();
        test_reg_err();
        test_back_to_back();
        test_early_psel();
        test_random();
`ifdef TAXI_APB_REG_BRIDGE_TIMEOUT_EN
        test_timeout();
        test_ack_at_timeout();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
